// File: rtl/ram_sync_init_if.sv
// Bus bundle for ram_sync_init. The master drives user requests, and the slave returns read data and status.
// Handshake: a request (re, or wpe&wren) is taken on any rising edge where busy=0. There is no backpressure beyond busy. ovalid marks the single output cycle that belongs to a taken read.
interface ram_sync_init_if #(
    parameter int WIDTH = 8,
    parameter int AW    = 4
);
    logic             clr;
    logic             wpe;
    logic             wren;
    logic [AW-1:0]    a;
    logic [WIDTH-1:0] d;
    logic             re;
    logic [WIDTH-1:0] o;
    logic             ovalid;
    logic             busy;
    logic             state_dbg;

    modport master (
        output clr, wpe, wren, a, d, re,
        input  o, ovalid, busy, state_dbg
    );

    modport slave (
        input  clr, wpe, wren, a, d, re,
        output o, ovalid, busy, state_dbg
    );
endinterface

// File: rtl/ram_sync_init.sv
// Single-port synchronous RAM with a built-in clear sequencer and an optional output register.
// Reads return the contents held before any same-cycle write, and out-of-range reads return zero.
module ram_sync_init #(
    parameter int               WIDTH    = 8,
    parameter int               DEPTH    = 16,
    parameter int               AW       = 4,
    parameter logic [WIDTH-1:0] INIT_VAL = '0,
    parameter bit               OUT_REG  = 1'b0
) (
    input  logic           clk,
    input  logic           rst,
    ram_sync_init_if.slave bus
);

    localparam logic [AW:0]   DEPTH_EXT = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    state_t           state, state_n;
    logic [AW-1:0]    ptr, ptr_n;
    logic             in_range;
    logic             user_wr;
    logic             user_rd;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid;

    always_comb begin
        in_range = ({1'b0, bus.a} < DEPTH_EXT);
        user_wr  = (state == READY) && bus.wpe && bus.wren && in_range;
        user_rd  = (state == READY) && bus.re;
    end

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        case (state)
            CLEAR: begin
                // clr is deliberately not looked at here, so a request mid-clear never restarts the sweep
                if (ptr == LAST_ADDR) begin
                    state_n = READY;
                    ptr_n   = '0;
                end else begin
                    ptr_n = ptr + 1'b1;
                end
            end
            READY: begin
                if (bus.clr) begin
                    state_n = CLEAR;
                    ptr_n   = '0;
                end
            end
            default: begin
                state_n = CLEAR;
                ptr_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CLEAR;
            ptr   <= '0;
        end else begin
            state <= state_n;
            ptr   <= ptr_n;
        end
    end

    // Storage has no reset, so contents are left alone while rst is held
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == CLEAR) begin
                mem[ptr] <= INIT_VAL;
            end else if (user_wr) begin
                mem[bus.a] <= bus.d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= user_rd;
            if (user_rd) begin
                rd_data <= in_range ? mem[bus.a] : '0;
            end
        end
    end

    assign bus.busy      = (state == CLEAR);
    assign bus.state_dbg = state;

    generate
        if (OUT_REG) begin : g_oreg
            logic [WIDTH-1:0] o_q;
            logic             ovalid_q;

            // Always advances, so a read taken before clr still drains out while busy is high
            always_ff @(posedge clk) begin
                if (rst) begin
                    o_q      <= '0;
                    ovalid_q <= 1'b0;
                end else begin
                    ovalid_q <= rd_valid;
                    if (rd_valid) begin
                        o_q <= rd_data;
                    end
                end
            end

            assign bus.o      = o_q;
            assign bus.ovalid = ovalid_q;
        end else begin : g_noreg
            assign bus.o      = rd_data;
            assign bus.ovalid = rd_valid;
        end
    endgenerate

endmodule

// File: tb/tb_ram_sync_init.sv
// Directed bench for ram_sync_init covering three configurations: 16x8 with latency 1,
// 12 words with latency 1, and 16x8 with latency 2. Each scenario task checks its own results.
module tb_ram_sync_init;

    logic clk;
    logic rst0, rst1, rst2;
    int   n_cmp;
    int   n_err;

    ram_sync_init_if #(.WIDTH(8), .AW(4)) bus0 ();
    ram_sync_init_if #(.WIDTH(8), .AW(4)) bus1 ();
    ram_sync_init_if #(.WIDTH(8), .AW(4)) bus2 ();

    ram_sync_init #(.WIDTH(8), .DEPTH(16), .AW(4), .INIT_VAL(8'h5A), .OUT_REG(1'b0)) u_d16 (
        .clk(clk), .rst(rst0), .bus(bus0.slave)
    );
    ram_sync_init #(.WIDTH(8), .DEPTH(12), .AW(4), .INIT_VAL(8'h3C), .OUT_REG(1'b0)) u_d12 (
        .clk(clk), .rst(rst1), .bus(bus1.slave)
    );
    ram_sync_init #(.WIDTH(8), .DEPTH(16), .AW(4), .INIT_VAL(8'h5A), .OUT_REG(1'b1)) u_oreg (
        .clk(clk), .rst(rst2), .bus(bus2.slave)
    );

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        bus0.clr = 0; bus0.wpe = 0; bus0.wren = 0; bus0.re = 0; bus0.a = '0; bus0.d = '0;
        bus1.clr = 0; bus1.wpe = 0; bus1.wren = 0; bus1.re = 0; bus1.a = '0; bus1.d = '0;
        bus2.clr = 0; bus2.wpe = 0; bus2.wren = 0; bus2.re = 0; bus2.a = '0; bus2.d = '0;
    endtask

    task automatic test_reset();
        int fall0, fall1, fall2;
        rst0 = 1; rst1 = 1; rst2 = 1;
        tick();
        tick();
        n_cmp++;
        if (bus0.busy !== 1'b1 || bus0.o !== 8'h00 || bus0.ovalid !== 1'b0 || bus0.state_dbg !== 1'b0) begin
            n_err++;
            $display("FAIL reset_d16: busy=%b o=%h ovalid=%b st=%b, want busy=1 o=00 ovalid=0 st=0",
                     bus0.busy, bus0.o, bus0.ovalid, bus0.state_dbg);
        end
        n_cmp++;
        if (bus2.busy !== 1'b1 || bus2.o !== 8'h00 || bus2.ovalid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_oreg: busy=%b o=%h ovalid=%b, want busy=1 o=00 ovalid=0",
                     bus2.busy, bus2.o, bus2.ovalid);
        end
        rst0 = 0; rst1 = 0; rst2 = 0;
        fall0 = 0; fall1 = 0; fall2 = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (fall0 == 0 && bus0.busy === 1'b0) fall0 = i;
            if (fall1 == 0 && bus1.busy === 1'b0) fall1 = i;
            if (fall2 == 0 && bus2.busy === 1'b0) fall2 = i;
        end
        n_cmp++;
        if (fall0 != 16) begin
            n_err++;
            $display("FAIL clear_len_d16: busy fell after %0d edges, want 16", fall0);
        end
        n_cmp++;
        if (fall1 != 12) begin
            n_err++;
            $display("FAIL clear_len_d12: busy fell after %0d edges, want 12", fall1);
        end
        n_cmp++;
        if (fall2 != 16) begin
            n_err++;
            $display("FAIL clear_len_oreg: busy fell after %0d edges, want 16", fall2);
        end
        n_cmp++;
        if (bus0.state_dbg !== 1'b1) begin
            n_err++;
            $display("FAIL ready_state: state_dbg=%b, want 1", bus0.state_dbg);
        end
    endtask

    task automatic test_init_read();
        for (int i = 0; i < 16; i++) begin
            bus0.re = 1; bus0.a = 4'(i);
            tick();
            n_cmp++;
            if (bus0.o !== 8'h5A || bus0.ovalid !== 1'b1) begin
                n_err++;
                $display("FAIL init_read[%0d]: o=%h ovalid=%b, want o=5a ovalid=1", i, bus0.o, bus0.ovalid);
            end
        end
        bus0.re = 0; bus0.a = 4'd2;
        tick();
        n_cmp++;
        if (bus0.o !== 8'h5A || bus0.ovalid !== 1'b0) begin
            n_err++;
            $display("FAIL idle_hold: o=%h ovalid=%b, want o=5a ovalid=0", bus0.o, bus0.ovalid);
        end
    endtask

    task automatic test_write_read();
        bus0.wpe = 1; bus0.wren = 1; bus0.a = 4'd3; bus0.d = 8'hC3;
        tick();
        bus0.wpe = 0; bus0.wren = 0; bus0.re = 1;
        tick();
        n_cmp++;
        if (bus0.o !== 8'hC3 || bus0.ovalid !== 1'b1) begin
            n_err++;
            $display("FAIL write_then_read: o=%h ovalid=%b, want o=c3 ovalid=1", bus0.o, bus0.ovalid);
        end
        bus0.wpe = 1; bus0.wren = 1; bus0.d = 8'h11;
        tick();
        n_cmp++;
        if (bus0.o !== 8'hC3) begin
            n_err++;
            $display("FAIL read_first_old: o=%h, want c3", bus0.o);
        end
        bus0.wpe = 0; bus0.wren = 0;
        tick();
        n_cmp++;
        if (bus0.o !== 8'h11 || bus0.ovalid !== 1'b1) begin
            n_err++;
            $display("FAIL read_first_new: o=%h ovalid=%b, want o=11 ovalid=1", bus0.o, bus0.ovalid);
        end
        bus0.re = 0;
    endtask

    task automatic test_write_enables();
        bus0.a = 4'd5; bus0.d = 8'hFF;
        bus0.wpe = 1; bus0.wren = 0;
        tick();
        bus0.wpe = 0; bus0.wren = 1;
        tick();
        bus0.wren = 0; bus0.re = 1;
        tick();
        n_cmp++;
        if (bus0.o !== 8'h5A) begin
            n_err++;
            $display("FAIL write_gating: word5=%h, want 5a", bus0.o);
        end
        bus0.re = 0;
    endtask

    task automatic test_out_of_range();
        bus1.wpe = 1; bus1.wren = 1; bus1.a = 4'd13; bus1.d = 8'hAA;
        tick();
        bus1.wpe = 0; bus1.wren = 0; bus1.re = 1; bus1.a = 4'd1;
        tick();
        n_cmp++;
        if (bus1.o !== 8'h3C) begin
            n_err++;
            $display("FAIL oor_write_alias: word1=%h, want 3c", bus1.o);
        end
        bus1.a = 4'd13;
        tick();
        n_cmp++;
        if (bus1.o !== 8'h00 || bus1.ovalid !== 1'b1) begin
            n_err++;
            $display("FAIL oor_read: o=%h ovalid=%b, want o=00 ovalid=1", bus1.o, bus1.ovalid);
        end
        bus1.re = 0; bus1.wpe = 1; bus1.wren = 1; bus1.a = 4'd11; bus1.d = 8'h77;
        tick();
        bus1.wpe = 0; bus1.wren = 0; bus1.re = 1;
        tick();
        n_cmp++;
        if (bus1.o !== 8'h77 || bus1.ovalid !== 1'b1) begin
            n_err++;
            $display("FAIL last_word: o=%h ovalid=%b, want o=77 ovalid=1", bus1.o, bus1.ovalid);
        end
        bus1.re = 0;
    endtask

    task automatic test_clear();
        int fall;
        bus0.wpe = 1; bus0.wren = 1; bus0.a = 4'd7; bus0.d = 8'hE7;
        tick();
        bus0.wpe = 0; bus0.wren = 0; bus0.re = 1; bus0.clr = 1;
        tick();
        n_cmp++;
        if (bus0.o !== 8'hE7 || bus0.ovalid !== 1'b1 || bus0.busy !== 1'b1) begin
            n_err++;
            $display("FAIL clr_same_cycle_read: o=%h ovalid=%b busy=%b, want o=e7 ovalid=1 busy=1",
                     bus0.o, bus0.ovalid, bus0.busy);
        end
        bus0.clr = 0; bus0.wpe = 1; bus0.wren = 1; bus0.a = 4'd2; bus0.d = 8'h99;
        tick();
        n_cmp++;
        if (bus0.ovalid !== 1'b0 || bus0.busy !== 1'b1) begin
            n_err++;
            $display("FAIL busy_ignore: ovalid=%b busy=%b, want ovalid=0 busy=1", bus0.ovalid, bus0.busy);
        end
        bus0.wpe = 0; bus0.wren = 0; bus0.re = 0;
        fall = 0;
        for (int i = 2; i <= 40; i++) begin
            bus0.clr = (i == 5);
            tick();
            if (fall == 0 && bus0.busy === 1'b0) fall = i;
        end
        bus0.clr = 0;
        n_cmp++;
        if (fall != 16) begin
            n_err++;
            $display("FAIL clr_len: busy fell %0d edges after clr, want 16", fall);
        end
        for (int i = 0; i < 16; i++) begin
            bus0.re = 1; bus0.a = 4'(i);
            tick();
            n_cmp++;
            if (bus0.o !== 8'h5A || bus0.ovalid !== 1'b1) begin
                n_err++;
                $display("FAIL after_clr[%0d]: o=%h ovalid=%b, want o=5a ovalid=1", i, bus0.o, bus0.ovalid);
            end
        end
        bus0.re = 0;
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_o [5];
        logic       exp_v [5];
        int fall;
        exp_o = '{8'h00, 8'hA0, 8'hA1, 8'hA2, 8'hA2};
        exp_v = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            bus2.wpe = 1; bus2.wren = 1; bus2.a = 4'(i); bus2.d = 8'hA0 + 8'(i);
            tick();
        end
        bus2.wpe = 0; bus2.wren = 0;
        for (int i = 0; i < 5; i++) begin
            bus2.re = (i < 3); bus2.a = 4'(i);
            tick();
            n_cmp++;
            if (bus2.o !== exp_o[i] || bus2.ovalid !== exp_v[i]) begin
                n_err++;
                $display("FAIL oreg_pipe[%0d]: o=%h ovalid=%b, want o=%h ovalid=%b",
                         i, bus2.o, bus2.ovalid, exp_o[i], exp_v[i]);
            end
        end
        bus2.re = 1; bus2.a = 4'd1; bus2.clr = 1;
        tick();
        bus2.re = 0; bus2.clr = 0;
        tick();
        n_cmp++;
        if (bus2.o !== 8'hA1 || bus2.ovalid !== 1'b1 || bus2.busy !== 1'b1) begin
            n_err++;
            $display("FAIL oreg_drain: o=%h ovalid=%b busy=%b, want o=a1 ovalid=1 busy=1",
                     bus2.o, bus2.ovalid, bus2.busy);
        end
        for (int i = 2; i <= 7; i++) tick();
        rst2 = 1;
        tick();
        n_cmp++;
        if (bus2.o !== 8'h00 || bus2.ovalid !== 1'b0 || bus2.busy !== 1'b1) begin
            n_err++;
            $display("FAIL mid_clear_rst: o=%h ovalid=%b busy=%b, want o=00 ovalid=0 busy=1",
                     bus2.o, bus2.ovalid, bus2.busy);
        end
        rst2 = 0;
        fall = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (fall == 0 && bus2.busy === 1'b0) fall = i;
        end
        n_cmp++;
        if (fall != 16) begin
            n_err++;
            $display("FAIL restart_len: busy fell %0d edges after rst, want 16", fall);
        end
        bus2.re = 1; bus2.a = 4'd1;
        tick();
        bus2.re = 0;
        tick();
        n_cmp++;
        if (bus2.o !== 8'h5A || bus2.ovalid !== 1'b1) begin
            n_err++;
            $display("FAIL oreg_after_clear: o=%h ovalid=%b, want o=5a ovalid=1", bus2.o, bus2.ovalid);
        end
    endtask

    // Sequencer and final report
    initial begin
        n_cmp = 0;
        n_err = 0;
        rst0 = 1; rst1 = 1; rst2 = 1;
        idle_all();
        test_reset();
        test_init_read();
        test_write_read();
        test_write_enables();
        test_out_of_range();
        test_clear();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
